// File: rtl/priority_demux_router_pkg.sv
// Shared definitions for the priority demux router: slot indices, slot count,
// default data width and the slot-index type used by the destination decoder.
// Optional feature macro: PRD_CNT_EN (adds the accepted-transfer counter).
package priority_demux_router_pkg;

  localparam int unsigned NSLOT          = 8;
  localparam int unsigned SLOT_IDX_W     = 3;
  localparam int unsigned PRD_DEFAULT_DW = 4;

  typedef logic [SLOT_IDX_W-1:0] slot_idx_t;

  localparam slot_idx_t SLOT_Z    = 3'd0;
  localparam slot_idx_t SLOT_HOLD = 3'd1;
  localparam slot_idx_t SLOT_A0   = 3'd2;
  localparam slot_idx_t SLOT_A1   = 3'd3;
  localparam slot_idx_t SLOT_B0   = 3'd4;
  localparam slot_idx_t SLOT_B1   = 3'd5;
  localparam slot_idx_t SLOT_B2   = 3'd6;
  localparam slot_idx_t SLOT_B3   = 3'd7;

  // The HOLD slot is an overwrite register and never back-pressures.
  function automatic logic is_hold(input slot_idx_t idx);
    return idx == SLOT_HOLD;
  endfunction

endpackage

// File: rtl/priority_demux_router_dest_dec.sv
// prd_dest_dec: combinational destination decoder. Maps the 4-bit priority
// code plus the A/B group sub-selects onto a 3-bit slot index. The lowest set
// bit of sel4 wins, mirroring the team's 4-bit priority multiplexer.
// Optional feature macro: PRD_CNT_EN (not used in this file).
module prd_dest_dec
  import priority_demux_router_pkg::*;
(
  input  logic [3:0] sel4_i,
  input  logic       sel2_i,
  input  logic [1:0] sel3_i,
  output slot_idx_t  dest_o
);

  // Priority decode: first matching pattern selects the slot.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves dest_o unassigned (no latch).
    dest_o = SLOT_B0;
    casez (sel4_i)
      4'b???1: dest_o = SLOT_Z;
      4'b??10: dest_o = SLOT_HOLD;
      4'b?100: dest_o = sel2_i ? SLOT_A1 : SLOT_A0;
      default: dest_o = {1'b1, sel3_i};  // 1000 and 0000: B group, SLOT_B0 + sel3
    endcase
  end

endmodule

// File: rtl/priority_demux_router.sv
// priority_demux_router: steers one DW-bit word per accepted transfer into one
// of eight registered, handshaked output slots. Slot 1 is an overwrite (HOLD)
// register; all others back-pressure while holding unconsumed data.
// Optional feature macro: PRD_CNT_EN (adds xfer_cnt, a CW-bit wrapping count
// of accepted transfers). With the macro undefined the port is absent.
module priority_demux_router
  import priority_demux_router_pkg::*;
#(
  parameter int DW = PRD_DEFAULT_DW
`ifdef PRD_CNT_EN
  , parameter int CW = 8
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DW-1:0]       in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          sel4,
  input  logic                sel2,
  input  logic [1:0]          sel3,
  output logic [NSLOT*DW-1:0] out_data,
  output logic [NSLOT-1:0]    out_valid,
  input  logic [NSLOT-1:0]    out_ack
`ifdef PRD_CNT_EN
  , output logic [CW-1:0]     xfer_cnt
`endif
);

  slot_idx_t                 dest;
  logic                      xfer;
  logic [NSLOT-1:0][DW-1:0]  data_q, data_d;
  logic [NSLOT-1:0]          valid_q, valid_d;

  prd_dest_dec u_dest_dec (
    .sel4_i (sel4),
    .sel2_i (sel2),
    .sel3_i (sel3),
    .dest_o (dest)
  );

  // Ready depends only on the selected slot's state and its ack, never on in_valid,
  // so the producer may look at in_ready before deciding to offer data.
  assign in_ready = is_hold(dest) | ~valid_q[dest] | out_ack[dest];
  assign xfer     = in_valid & in_ready;

  assign out_data  = data_q;
  assign out_valid = valid_q;

  // Next-state for every slot: ack clears valid, a write to the slot overrides the ack.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    for (int k = 0; k < NSLOT; k++) begin
      if (out_ack[k]) begin
        valid_d[k] = 1'b0;
      end
      if (xfer && dest == slot_idx_t'(k)) begin
        data_d[k]  = in_data;
        valid_d[k] = 1'b1;
      end
    end
  end

  // Slot registers with synchronous reset that dominates acks and transfers.
  always_ff @(posedge clk) begin
    // NOTE: the slot data registers are reset too, because out_data must read 0 after reset.
    if (reset) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all slots update together.
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

`ifdef PRD_CNT_EN
  logic [CW-1:0] cnt_q, cnt_d;

  assign cnt_d    = xfer ? cnt_q + CW'(1) : cnt_q;
  assign xfer_cnt = cnt_q;

  // Accepted-transfer counter, wraps naturally at 2^CW.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: doc/priority_demux_router.md
# priority_demux_router

Priority-decoded 1-to-8 data distributor with registered, handshaked outputs. Takes one DW-bit input word per accepted transfer and steers it to one of eight output holding registers; destination selection uses the same priority encoding as the team's 4-bit priority multiplexer, run in the opposite direction. Sits between a single producer and up to eight independent consumers, each draining its own slot.

## Interface
- DW, 4, data width of input word and every output slot
- CW, 8, width of transfer counter (only with PRD_CNT_EN)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_data  input  DW  word to distribute
- in_valid  input  1  producer offers in_data
- in_ready  output  1  block accepts this cycle (combinational)
- sel4  input  4  priority destination code
- sel2  input  1  sub-select for A group
- sel3  input  2  sub-select for B group
- out_data  output  8*DW  slot k at bits [k*DW +: DW]
- out_valid  output  8  slot k holds unconsumed data
- out_ack  input  8  consumer k takes slot k this cycle
- xfer_cnt  output  CW  accepted-transfer count (PRD_CNT_EN only)

Clock `clk`; reset `reset`, synchronous, active-high.

## Operation
- Destination decode (casez on sel4, first match wins):
  - ???1 -> slot 0 (Z)
  - ??10 -> slot 1 (HOLD)
  - ?100 -> slot 2 if sel2=0, slot 3 if sel2=1 (A group)
  - 1000, 0000 -> slot 4+sel3 (B group, slots 4..7)
- Transfer = in_valid & in_ready at a rising edge.
- in_ready = 1 when destination slot is HOLD, or out_valid[dest]=0, or out_ack[dest]=1; else 0. Depends on sel4/sel2/sel3 of the same cycle; must not depend on in_valid.
- Slots 0, 2..7 (queued): transfer loads data, sets valid. Ack with valid=1 clears valid. Ack with valid=0 ignored. Ack and write to same slot in same cycle: new data loaded, valid stays 1.
- Slot 1 (HOLD): overwrite register, never back-pressures. Write replaces data, sets valid; out_ack[1] clears valid, data retained. Simultaneous write and ack: write wins, valid=1.
- Only the destination slot changes on a transfer; other slots keep state and may be acked independently in the same cycle.
- in_valid=0: no slot written regardless of selects.

## Timing
- Reset (synchronous, dominates all inputs): out_data all 0, out_valid 8'h00, xfer_cnt 0. Pending data discarded; acks and transfers in the reset cycle ignored.
- Latency: transfer at edge N -> out_data slot and out_valid visible after edge N (one cycle).
- Ack at edge N -> out_valid low after edge N.
- in_ready combinational; after reset, in_ready=1 for every destination.
- Full throughput: one transfer per cycle when consumers ack each cycle or destinations rotate.

## Configuration
- PRD_CNT_EN defined: xfer_cnt port present; increments by 1 on every transfer, wraps 2^CW-1 -> 0; reset to 0.
- Not defined: port and counter absent; all other behaviour identical.

## Structure
- Shared package: slot index constants (SLOT_Z=0, SLOT_HOLD=1, SLOT_A0=2, SLOT_A1=3, SLOT_B0..SLOT_B3=4..7), NSLOT=8, default DW.
- One sub-module: prd_dest_dec, combinational, maps sel4/sel2/sel3 to 3-bit slot index; reused by verification reference model.

## Test plan
- Reset, then sel4=4'b0011, in_data=4'h5, in_valid=1 one cycle -> next cycle out_valid=8'h01, slot 0=4'h5; other slots 0.
- Write slot 2 (sel4=4'b0100, sel2=0, data 4'hA), no ack, retry same destination with 4'hB -> in_ready=0, slot 2 stays 4'hA; assert out_ack[2] -> same cycle in_ready=1, slot 2 becomes 4'hB, valid stays 1.
- sel4=4'b0000, sel3=2'b10 data 4'h3, then sel4=4'b1000, sel3=2'b11 data 4'h7 -> slots 6=4'h3 and 7=4'h7, out_valid=8'hC0.
- HOLD: sel4=4'b0010 writes 4'h1 then 4'h2 with no ack -> in_ready stays 1, slot 1=4'h2; out_ack[1] -> valid[1]=0, data still 4'h2.
- Fill slots 0,2,5, assert reset with in_valid=1 and acks -> after edge all out_valid=0, all data 0, xfer_cnt=0.
- PRD_CNT_EN with CW=8: 257 back-to-back transfers to HOLD -> xfer_cnt=1 (wrapped).
